// File: rtl/dma_pkg.sv
// Shared definitions for the DMA channel controller: register map,
// CTRL/STATUS bit positions, FSM state encoding and a small helper.
package dma_pkg;

  localparam logic [2:0] REG_SRC       = 3'd0;
  localparam logic [2:0] REG_DST       = 3'd1;
  localparam logic [2:0] REG_LEN       = 3'd2;
  localparam logic [2:0] REG_CTRL      = 3'd3;
  localparam logic [2:0] REG_STATUS    = 3'd4;
  localparam logic [2:0] REG_REMAINING = 3'd5;

  localparam int unsigned CTRL_GO     = 0;
  localparam int unsigned CTRL_IRQ_EN = 1;
  localparam int unsigned CTRL_STOP   = 2;

  localparam int unsigned STAT_BUSY    = 0;
  localparam int unsigned STAT_DONE    = 1;
  localparam int unsigned STAT_ERR     = 2;
  localparam int unsigned STAT_ABORTED = 3;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CHECK   = 3'd1,
    S_ISSUE   = 3'd2,
    S_RUN     = 3'd3,
    S_ADVANCE = 3'd4,
    S_FINISH  = 3'd5
  } state_t;

  function automatic logic [31:0] min32(input logic [31:0] a, input logic [31:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/dma_ctrl_regs.sv
// Avalon-MM slave for the DMA channel: register decode, registered
// readback, sticky W1C status bits and the registered interrupt line.
module dma_ctrl_regs
  import dma_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [2:0]  addr_i,
  input  logic        write_i,
  input  logic [31:0] wdata_i,
  input  logic        read_i,
  output logic [31:0] rdata_o,
  input  logic        busy_i,
  input  logic [31:0] remaining_i,
  input  logic        set_done_i,
  input  logic        set_err_i,
  input  logic        set_abort_i,
  output logic [31:0] src_o,
  output logic [31:0] dst_o,
  output logic [31:0] len_o,
  output logic        go_o,
  output logic        stop_o,
  output logic        irq_o
);

  logic [31:0] src_q, src_d;
  logic [31:0] dst_q, dst_d;
  logic [31:0] len_q, len_d;
  logic [31:0] rdata_q, rdata_d;
  logic        irq_en_q, irq_en_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        abort_q, abort_d;
  logic        irq_q, irq_d;
  logic        wr_ctrl;
  logic        wr_status;

  assign wr_ctrl   = write_i && (addr_i == REG_CTRL);
  assign wr_status = write_i && (addr_i == REG_STATUS);

  // GO together with STOP is dropped so an idle channel neither starts nor aborts
  assign go_o   = wr_ctrl && wdata_i[CTRL_GO] && !wdata_i[CTRL_STOP] && !busy_i;
  assign stop_o = wr_ctrl && wdata_i[CTRL_STOP];

  // Next-state for configuration, sticky status, interrupt and read data
  always_comb begin
    src_d    = src_q;
    dst_d    = dst_q;
    len_d    = len_q;
    irq_en_d = irq_en_q;
    rdata_d  = rdata_q;

    if (write_i && !busy_i) begin
      case (addr_i)
        REG_SRC: src_d = wdata_i;
        REG_DST: dst_d = wdata_i;
        REG_LEN: len_d = wdata_i;
        default: ;
      endcase
    end
    if (wr_ctrl) irq_en_d = wdata_i[CTRL_IRQ_EN];

    // Hardware set wins over a same-cycle software clear
    done_d  = set_done_i  | (done_q  & ~(wr_status & wdata_i[STAT_DONE]));
    err_d   = set_err_i   | (err_q   & ~(wr_status & wdata_i[STAT_ERR]));
    abort_d = set_abort_i | (abort_q & ~(wr_status & wdata_i[STAT_ABORTED]));

    // Interrupt tracks the post-update status so a W1C drops it on the same edge
    irq_d = irq_en_d & (done_d | err_d | abort_d);

    if (read_i) begin
      case (addr_i)
        REG_SRC:       rdata_d = src_q;
        REG_DST:       rdata_d = dst_q;
        REG_LEN:       rdata_d = len_q;
        REG_CTRL:      rdata_d = {29'b0, 1'b0, irq_en_q, 1'b0};
        REG_STATUS:    rdata_d = {28'b0, abort_q, err_q, done_q, busy_i};
        REG_REMAINING: rdata_d = remaining_i;
        default:       rdata_d = '0;
      endcase
    end
  end

  // Register state update
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      src_q    <= '0;
      dst_q    <= '0;
      len_q    <= '0;
      rdata_q  <= '0;
      irq_en_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      abort_q  <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      src_q    <= src_d;
      dst_q    <= dst_d;
      len_q    <= len_d;
      rdata_q  <= rdata_d;
      irq_en_q <= irq_en_d;
      done_q   <= done_d;
      err_q    <= err_d;
      abort_q  <= abort_d;
      irq_q    <= irq_d;
    end
  end

  assign src_o   = src_q;
  assign dst_o   = dst_q;
  assign len_o   = len_q;
  assign rdata_o = rdata_q;
  assign irq_o   = irq_q;

endmodule

// File: rtl/dma_channel_ctrl.sv
// DMA channel controller: splits a programmed transfer into chunks of at
// most MAX_CHUNK bytes and sequences the read/write masters per chunk.
module dma_channel_ctrl
  import dma_pkg::*;
#(
  parameter int unsigned MAX_CHUNK = 256
) (
  input  logic        iClk,
  input  logic        iReset_n,
  input  logic [2:0]  iCS_address,
  input  logic        iCS_write,
  input  logic [31:0] iCS_writedata,
  input  logic        iCS_read,
  output logic [31:0] oCS_readdata,
  output logic        oStart,
  output logic [31:0] oRM_startaddress,
  output logic [31:0] oWM_startaddress,
  output logic [31:0] oLength,
  input  logic        iRM_done,
  input  logic        iWM_done,
  output logic        oIRQ
);

  localparam logic [31:0] MaxChunkW = 32'(MAX_CHUNK);

  state_t      state_q;
  logic [31:0] cur_src_q, cur_dst_q, remaining_q, chunk_q;
  logic [31:0] rm_addr_q, wm_addr_q, len_q;
  logic        start_q;
  logic        rm_seen_q, wm_seen_q;
  logic        rm_prev_q, wm_prev_q;

  logic [31:0] cfg_src, cfg_dst, cfg_len;
  logic [31:0] rem_after;
  logic        busy, go, stop, bad_len;
  logic        set_done, set_err, set_abort;

  assign busy      = (state_q != S_IDLE);
  assign rem_after = remaining_q - chunk_q;
  assign bad_len   = (remaining_q == '0) || (remaining_q[1:0] != 2'b00);
  assign set_abort = stop && (state_q inside {S_CHECK, S_ISSUE, S_RUN, S_ADVANCE});
  assign set_err   = (state_q == S_CHECK) && bad_len && !stop;
  assign set_done  = (state_q == S_FINISH);

  dma_ctrl_regs u_regs (
    .clk_i       (iClk),
    .rst_ni      (iReset_n),
    .addr_i      (iCS_address),
    .write_i     (iCS_write),
    .wdata_i     (iCS_writedata),
    .read_i      (iCS_read),
    .rdata_o     (oCS_readdata),
    .busy_i      (busy),
    .remaining_i (remaining_q),
    .set_done_i  (set_done),
    .set_err_i   (set_err),
    .set_abort_i (set_abort),
    .src_o       (cfg_src),
    .dst_o       (cfg_dst),
    .len_o       (cfg_len),
    .go_o        (go),
    .stop_o      (stop),
    .irq_o       (oIRQ)
  );

  // Chunk sequencer with registered master-facing outputs
  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      state_q     <= S_IDLE;
      cur_src_q   <= '0;
      cur_dst_q   <= '0;
      remaining_q <= '0;
      chunk_q     <= '0;
      rm_addr_q   <= '0;
      wm_addr_q   <= '0;
      len_q       <= '0;
      start_q     <= 1'b0;
      rm_seen_q   <= 1'b0;
      wm_seen_q   <= 1'b0;
      rm_prev_q   <= 1'b0;
      wm_prev_q   <= 1'b0;
    end else begin
      // Done levels are tracked every cycle so a level left over from the
      // previous chunk never looks like a fresh rising edge in RUN
      rm_prev_q <= iRM_done;
      wm_prev_q <= iWM_done;

      if (set_abort) begin
        start_q <= 1'b0;
        state_q <= S_IDLE;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (go) begin
              cur_src_q   <= cfg_src;
              cur_dst_q   <= cfg_dst;
              remaining_q <= cfg_len;
              state_q     <= S_CHECK;
            end
          end
          S_CHECK: begin
            state_q <= bad_len ? S_IDLE : S_ISSUE;
          end
          S_ISSUE: begin
            chunk_q   <= min32(remaining_q, MaxChunkW);
            len_q     <= min32(remaining_q, MaxChunkW);
            rm_addr_q <= cur_src_q;
            wm_addr_q <= cur_dst_q;
            rm_seen_q <= 1'b0;
            wm_seen_q <= 1'b0;
            start_q   <= 1'b1;
            state_q   <= S_RUN;
          end
          S_RUN: begin
            if (iRM_done && !rm_prev_q) rm_seen_q <= 1'b1;
            if (iWM_done && !wm_prev_q) wm_seen_q <= 1'b1;
            if (rm_seen_q && wm_seen_q) begin
              start_q <= 1'b0;
              state_q <= S_ADVANCE;
            end
          end
          S_ADVANCE: begin
            remaining_q <= rem_after;
            cur_src_q   <= cur_src_q + chunk_q;
            cur_dst_q   <= cur_dst_q + chunk_q;
            state_q     <= (rem_after == '0) ? S_FINISH : S_ISSUE;
          end
          S_FINISH: begin
            state_q <= S_IDLE;
          end
          default: begin
            start_q <= 1'b0;
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign oStart           = start_q;
  assign oRM_startaddress = rm_addr_q;
  assign oWM_startaddress = wm_addr_q;
  assign oLength          = len_q;

endmodule

// File: tb/tb_dma_channel_ctrl.sv
// Scoreboard bench for dma_channel_ctrl: chunk and read expectations are
// queued by the stimulus and retired by a negedge monitor.
module tb_dma_channel_ctrl;

  localparam int unsigned MAXC = 256;

  logic        iClk = 1'b0;
  logic        iReset_n;
  logic [2:0]  iCS_address;
  logic        iCS_write;
  logic [31:0] iCS_writedata;
  logic        iCS_read;
  logic [31:0] oCS_readdata;
  logic        oStart;
  logic [31:0] oRM_startaddress, oWM_startaddress, oLength;
  logic        iRM_done, iWM_done;
  logic        oIRQ;

  always #5 iClk = ~iClk;

  dma_channel_ctrl #(.MAX_CHUNK(MAXC)) dut (
    .iClk             (iClk),
    .iReset_n         (iReset_n),
    .iCS_address      (iCS_address),
    .iCS_write        (iCS_write),
    .iCS_writedata    (iCS_writedata),
    .iCS_read         (iCS_read),
    .oCS_readdata     (oCS_readdata),
    .oStart           (oStart),
    .oRM_startaddress (oRM_startaddress),
    .oWM_startaddress (oWM_startaddress),
    .oLength          (oLength),
    .iRM_done         (iRM_done),
    .iWM_done         (iWM_done),
    .oIRQ             (oIRQ)
  );

  typedef struct { logic [31:0] src; logic [31:0] dst; logic [31:0] len; } chunk_t;
  typedef struct { logic [2:0] addr; logic [31:0] data; } rd_t;

  chunk_t chunk_q[$];
  rd_t    rd_q[$];

  int unsigned checks = 0;
  int unsigned failures = 0;

  // monitor-owned
  int unsigned started_cnt = 0;
  int unsigned complete_cnt = 0;
  int unsigned abort_ack = 0;
  logic        prev_start = 1'b0;
  // stimulus-owned
  int unsigned abort_req = 0;
  int unsigned fixed_delay = 0;
  bit          sticky_done = 1'b0;
  // master-owned: index of the chunk each master last answered
  int unsigned rm_answered = 0;
  int unsigned wm_answered = 0;

  // reference model of the programmer-visible registers
  logic [31:0] m_src, m_dst, m_len, m_rem;
  logic        m_irq_en, m_done, m_err, m_abort;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  function automatic int unsigned pick_delay();
    return (fixed_delay != 0) ? fixed_delay : 2 + $urandom_range(0, 10);
  endfunction

  function automatic logic [31:0] exp_status();
    return {28'b0, m_abort, m_err, m_done, 1'b0};
  endfunction

  function automatic logic exp_irq();
    return m_irq_en & (m_done | m_err | m_abort);
  endfunction

  // Monitor: retires read and chunk expectations, checks completions
  always @(negedge iClk) begin
    rd_t    r;
    chunk_t c;
    if (rd_q.size() > 0) begin
      r = rd_q.pop_front();
      check32($sformatf("read_addr%0d", r.addr), oCS_readdata, r.data);
    end
    if (oStart && !prev_start) begin
      started_cnt++;
      if (chunk_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_start actual=len 0x%08h expected=no chunk", oLength);
      end else begin
        c = chunk_q.pop_front();
        check32("chunk_src", oRM_startaddress, c.src);
        check32("chunk_dst", oWM_startaddress, c.dst);
        check32("chunk_len", oLength, c.len);
      end
    end
    if (!oStart && prev_start) begin
      if (abort_req != abort_ack) abort_ack++;
      else begin
        check32("chunk_fresh_done", {31'b0, (rm_answered == started_cnt) && (wm_answered == started_cnt)}, 32'd1);
        complete_cnt++;
      end
    end
    prev_start = oStart;
  end

  // Read master model: done after a delay, level lingers after oStart drops
  initial begin : rm_master
    int unsigned seen, linger;
    seen = 0; linger = 0; iRM_done = 1'b0;
    forever begin
      @(negedge iClk);
      if (started_cnt != seen) begin
        seen = started_cnt;
        iRM_done = 1'b0;
        repeat (pick_delay()) @(negedge iClk);
        rm_answered = seen;
        iRM_done = 1'b1;
        linger = sticky_done ? 4 : $urandom_range(0, 3);
      end else if (iRM_done && !oStart) begin
        if (linger == 0) iRM_done = 1'b0; else linger--;
      end
    end
  end

  // Write master model, independent delays
  initial begin : wm_master
    int unsigned seen, linger;
    seen = 0; linger = 0; iWM_done = 1'b0;
    forever begin
      @(negedge iClk);
      if (started_cnt != seen) begin
        seen = started_cnt;
        iWM_done = 1'b0;
        repeat (pick_delay()) @(negedge iClk);
        wm_answered = seen;
        iWM_done = 1'b1;
        linger = sticky_done ? 4 : $urandom_range(0, 3);
      end else if (iWM_done && !oStart) begin
        if (linger == 0) iWM_done = 1'b0; else linger--;
      end
    end
  end

  // Bus tasks assume entry at posedge+1 and return at posedge+1
  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    iCS_address = a; iCS_writedata = d; iCS_write = 1'b1;
    @(posedge iClk); #1;
    iCS_write = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] a, input logic [31:0] exp);
    rd_t r;
    iCS_address = a; iCS_read = 1'b1;
    @(posedge iClk);
    r.addr = a; r.data = exp;
    rd_q.push_back(r);
    #1 iCS_read = 1'b0;
  endtask

  task automatic setup(input logic [31:0] s, input logic [31:0] d, input logic [31:0] l, input logic ie);
    bus_write(3'd4, 32'hE);
    m_done = 1'b0; m_err = 1'b0; m_abort = 1'b0;
    bus_write(3'd3, {30'b0, ie, 1'b0});
    m_irq_en = ie;
    bus_write(3'd0, s); bus_write(3'd1, d); bus_write(3'd2, l);
    m_src = s; m_dst = d; m_len = l;
  endtask

  // Queue the model's chunk split; returns chunk count (0 for an invalid length)
  task automatic plan_chunks(input int unsigned limit, output int unsigned n);
    logic [31:0] rem, s, d, c;
    n = 0;
    if (m_len == 0 || m_len % 4 != 0) return;
    rem = m_len; s = m_src; d = m_dst;
    while (rem != 0) begin
      c = (rem < MAXC) ? rem : MAXC;
      if (n < limit) chunk_q.push_back('{s, d, c});
      n++; rem -= c; s += c; d += c;
    end
  endtask

  task automatic do_transfer(input logic [31:0] s, input logic [31:0] d, input logic [31:0] l, input logic ie);
    int unsigned n, base;
    setup(s, d, l, ie);
    plan_chunks(1000, n);
    base = complete_cnt;
    bus_write(3'd3, {29'b0, 1'b0, ie, 1'b1});
    if (n != 0) begin
      // both land while the channel is busy and must be ignored
      bus_write(3'd0, ~s);
      bus_write(3'd3, {29'b0, 1'b0, ie, 1'b1});
    end
    for (int i = 0; i < 20000 && complete_cnt != base + n; i++) @(negedge iClk);
    check32("xfer_complete", complete_cnt, base + n);
    @(posedge iClk); #1;
    repeat (4) begin @(posedge iClk); #1; end
    check32("chunks_left", chunk_q.size(), 0);
    if (n == 0) begin m_err = 1'b1; m_rem = l; end
    else begin m_done = 1'b1; m_rem = '0; end
    bus_read(3'd4, exp_status());
    bus_read(3'd5, m_rem);
    bus_read(3'd0, m_src);
    bus_read(3'd2, m_len);
    check32("irq", {31'b0, oIRQ}, {31'b0, exp_irq()});
  endtask

  initial begin
    int unsigned n, base;
    logic [31:0] rl;
    iReset_n = 1'b0; iCS_address = '0; iCS_write = 1'b0; iCS_writedata = '0; iCS_read = 1'b0;
    m_src = '0; m_dst = '0; m_len = '0; m_rem = '0;
    m_irq_en = 1'b0; m_done = 1'b0; m_err = 1'b0; m_abort = 1'b0;
    #12;
    check32("rst_start", {31'b0, oStart}, 0);
    check32("rst_irq", {31'b0, oIRQ}, 0);
    check32("rst_rdata", oCS_readdata, 0);
    check32("rst_len", oLength, 0);
    check32("rst_rm_addr", oRM_startaddress, 0);
    check32("rst_wm_addr", oWM_startaddress, 0);
    #10 iReset_n = 1'b1;
    @(posedge iClk); #1;
    bus_read(3'd4, 32'h0);
    bus_read(3'd6, 32'h0);
    bus_read(3'd7, 32'h0);

    // single chunk, masters answer after 10 cycles
    fixed_delay = 10;
    do_transfer(32'h1000, 32'h2000, 32'h40, 1'b1);
    fixed_delay = 0;
    bus_read(3'd3, 32'h2);

    // three chunks of 0x100, 0x100, 0x50
    do_transfer(32'h1000, 32'h2000, 32'h250, 1'b0);

    // bad lengths raise ERR and IRQ, W1C drops IRQ
    do_transfer(32'h1000, 32'h2000, 32'h3, 1'b1);
    bus_write(3'd4, 32'h4); m_err = 1'b0;
    @(negedge iClk);
    check32("irq_after_w1c", {31'b0, oIRQ}, 0);
    @(posedge iClk); #1;
    do_transfer(32'h1000, 32'h2000, 32'h0, 1'b1);

    // done levels lingering into the next RUN must not advance it
    sticky_done = 1'b1;
    do_transfer(32'h4000, 32'h8000, 32'h300, 1'b0);
    sticky_done = 1'b0;

    // address wrap-around across chunks
    do_transfer(32'hFFFF_FF80, 32'hFFFF_FFC0, 32'h200, 1'b1);

    // GO and STOP together while idle: nothing starts, nothing aborts
    setup(32'h1000, 32'h2000, 32'h40, 1'b0);
    bus_write(3'd3, 32'h5);
    repeat (6) begin @(posedge iClk); #1; end
    m_rem = 32'h0;
    bus_read(3'd4, exp_status());

    // STOP during RUN of chunk 2 of 3
    setup(32'h1000, 32'h2000, 32'h250, 1'b1);
    plan_chunks(2, n);
    base = started_cnt;
    bus_write(3'd3, 32'h3);
    for (int i = 0; i < 2000 && started_cnt != base + 2; i++) @(negedge iClk);
    check32("stop_reached_chunk2", started_cnt, base + 2);
    @(posedge iClk); #1;
    abort_req++;
    bus_write(3'd3, 32'h6);
    @(negedge iClk);
    check32("stop_start_low", {31'b0, oStart}, 0);
    @(posedge iClk); #1;
    repeat (3) begin @(posedge iClk); #1; end
    m_abort = 1'b1; m_rem = 32'h150;
    bus_read(3'd4, exp_status());
    bus_read(3'd5, m_rem);
    check32("stop_irq", {31'b0, oIRQ}, {31'b0, exp_irq()});
    check32("stop_chunks_left", chunk_q.size(), 0);

    // randomized transfers
    for (int t = 0; t < 6; t++) begin
      rl = ($urandom_range(0, 4) == 0) ? 32'($urandom_range(0, 15)) : 32'($urandom_range(1, 384) * 4);
      do_transfer($urandom, $urandom, rl, 1'($urandom_range(0, 1)));
    end

    // reset asserted mid-RUN
    setup(32'h1000, 32'h2000, 32'h200, 1'b1);
    plan_chunks(1, n);
    base = started_cnt;
    bus_write(3'd3, 32'h3);
    for (int i = 0; i < 2000 && started_cnt != base + 1; i++) @(negedge iClk);
    check32("rst_reached_run", started_cnt, base + 1);
    #2;
    abort_req++;
    iReset_n = 1'b0;
    #1;
    check32("midrst_start", {31'b0, oStart}, 0);
    check32("midrst_irq", {31'b0, oIRQ}, 0);
    check32("midrst_rdata", oCS_readdata, 0);
    check32("midrst_len", oLength, 0);
    check32("midrst_rm_addr", oRM_startaddress, 0);
    check32("midrst_wm_addr", oWM_startaddress, 0);
    chunk_q.delete();
    m_src = '0; m_dst = '0; m_len = '0; m_rem = '0;
    m_irq_en = 1'b0; m_done = 1'b0; m_err = 1'b0; m_abort = 1'b0;
    repeat (2) @(negedge iClk);
    iReset_n = 1'b1;
    @(posedge iClk); #1;
    repeat (30) begin @(posedge iClk); #1; end
    bus_read(3'd4, 32'h0);
    bus_read(3'd5, 32'h0);
    bus_read(3'd0, 32'h0);
    bus_read(3'd3, 32'h0);
    check32("postrst_irq", {31'b0, oIRQ}, 0);
    check32("postrst_start", {31'b0, oStart}, 0);
    @(negedge iClk);
    @(negedge iClk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dma_channel_ctrl.md
DMA_CHANNEL_CTRL -- requirements
Module: dma_channel_ctrl

Interface
REQ-001 SHALL have parameter MAX_CHUNK, default 256, meaning maximum bytes per master transfer; it is a multiple of 4 and at least 4.
REQ-002 SHALL have port iClk, input, 1, the single system clock; all logic is on its rising edge.
REQ-003 SHALL have port iReset_n, input, 1, reset that is asynchronous and active-low.
REQ-004 SHALL have port iCS_address, input, 3, register word select for the Avalon-MM slave.
REQ-005 SHALL have ports iCS_write, input, 1, and iCS_writedata, input, 32, the slave write strobe and write data.
REQ-006 SHALL have ports iCS_read, input, 1, and oCS_readdata, output, 32, the slave read strobe and read data.
REQ-007 SHALL have port oStart, output, 1, a level held high for the whole of each chunk, to the read and write masters.
REQ-008 SHALL have ports oRM_startaddress, oWM_startaddress and oLength, outputs, 32 each, giving the chunk source address, destination address and byte count.
REQ-009 SHALL have ports iRM_done and iWM_done, inputs, 1 each, the level-held done flags from the masters.
REQ-010 SHALL have port oIRQ, output, 1, the interrupt request.

Function
REQ-011 Register map SHALL be: 0 SRC, 1 DST, 2 LEN (read/write); 3 CTRL; 4 STATUS; 5 REMAINING (read-only); 6 and 7 read as 0.
REQ-012 CTRL SHALL hold: bit0 GO (self-clearing, reads 0), bit1 IRQ_EN (stored), bit2 STOP (self-clearing, reads 0).
REQ-013 STATUS SHALL hold: bit0 BUSY (read-only), bit1 DONE, bit2 ERR, bit3 ABORTED; bits 1-3 are sticky and write-1-to-clear.
REQ-014 Reads SHALL have 1-cycle latency: oCS_readdata is registered on the cycle iCS_read is high and held until the next read.
REQ-015 Writes to SRC, DST or LEN while BUSY=1 SHALL be ignored.
REQ-016 A GO write while BUSY=1 SHALL be ignored.
REQ-017 The FSM states SHALL be IDLE, CHECK, ISSUE, RUN, ADVANCE, FINISH.
REQ-018 IDLE: on a GO write, the FSM SHALL go to CHECK and latch SRC, DST and LEN into working registers cur_src, cur_dst and remaining.
REQ-019 CHECK: if remaining==0 or remaining[1:0]!=0, the FSM SHALL set ERR and go to IDLE without asserting oStart; otherwise it goes to ISSUE.
REQ-020 ISSUE: the FSM SHALL set chunk = min(remaining, MAX_CHUNK), drive oLength=chunk, oRM_startaddress=cur_src and oWM_startaddress=cur_dst, clear both done_seen flags, and go to RUN.
REQ-021 RUN: oStart SHALL be 1; done_seen_x sets only on a 0->1 edge of iX_done, because the previous chunk's done level may persist 1-2 cycles after restart; when both flags are set, the FSM goes to ADVANCE.
REQ-022 ADVANCE: oStart SHALL be 0, remaining-=chunk, cur_src+=chunk and cur_dst+=chunk using 32-bit wrap-around arithmetic; the FSM goes to FINISH if the new remaining==0, else to ISSUE.
REQ-023 FINISH: the FSM SHALL set DONE and go to IDLE.
REQ-024 A STOP write in CHECK, ISSUE, RUN or ADVANCE SHALL force oStart=0 on the next cycle, set ABORTED, leave DONE unchanged, and return to IDLE.
REQ-025 BUSY SHALL equal (state!=IDLE).
REQ-026 If GO and STOP are written together in IDLE, the transfer SHALL NOT start and ABORTED SHALL NOT be set.
REQ-027 oIRQ SHALL be registered and equal IRQ_EN & (DONE | ERR | ABORTED).
REQ-028 A simultaneous FSM set and software clear of the same STATUS bit SHALL resolve with the set winning.
REQ-029 REMAINING SHALL read the live remaining counter.
REQ-030 oStart SHALL be 1 only in RUN; with no STOP, minimum chunk overhead is 3 cycles (ISSUE, ADVANCE, plus one edge-detect cycle).

Reset
REQ-031 While iReset_n=0, all outputs SHALL be 0: oStart, oIRQ, oCS_readdata, oLength, and both start addresses.
REQ-032 While iReset_n=0, all registers and STATUS bits SHALL be 0 and the state SHALL be IDLE.
REQ-033 Reset asserted mid-transfer SHALL drop oStart asynchronously, with no DONE or ABORTED set after release.

Structure
REQ-034 Register offsets, CTRL/STATUS bit positions and the FSM state encoding SHALL reside in the shared package dma_pkg.
REQ-035 One sub-module, dma_ctrl_regs (slave decode, readback and W1C logic), SHALL be instantiated; the FSM stays in the top level.

Verification
REQ-036 SRC=0x1000, DST=0x2000, LEN=0x40, GO, masters report done after 10 cycles -> one chunk with oLength=0x40; DONE=1; REMAINING=0; BUSY=0.
REQ-037 LEN=0x250, MAX_CHUNK=256 -> chunks 0x100, 0x100 and 0x50, with dst 0x2000, 0x2100, 0x2200; oStart low for at least one cycle between chunks.
REQ-038 LEN=0x3 or LEN=0 with GO -> ERR=1, oStart never asserts; with IRQ_EN=1, oIRQ=1; W1C of ERR -> oIRQ=0 on the next cycle.
REQ-039 STOP written during RUN of chunk 2 of 3 -> oStart=0 on the next cycle, ABORTED=1, DONE=0, REMAINING=0x150.
REQ-040 iWM_done held high from the previous chunk into the next RUN -> no premature ADVANCE; completion waits for a fresh rising edge.
REQ-041 iReset_n pulsed low mid-RUN -> all outputs 0 immediately; after release, STATUS reads 0.
